// File: rtl/lsu_sequencer_if.sv
// Data-bus interface between the load/store sequencer and the memory system.
//   o_bus_req   : beat request, held with address/enables/data until acked
//   o_bus_addr  : word-aligned byte address (bits [1:0] always zero)
//   o_bus_we    : per-byte write enables, all zero for loads
//   o_bus_wdata : write data, already rotated into its byte lanes
//   i_bus_ack   : beat acknowledge; read data valid in the same cycle
//   i_bus_rdata : read data
// Signal names carry the direction as seen from the sequencer.
interface lsu_sequencer_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              o_bus_req;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [3:0]        o_bus_we;
  logic [31:0]       o_bus_wdata;
  logic              i_bus_ack;
  logic [31:0]       i_bus_rdata;

  modport master (
    output o_bus_req,
    output o_bus_addr,
    output o_bus_we,
    output o_bus_wdata,
    input  i_bus_ack,
    input  i_bus_rdata
  );

  modport slave (
    input  o_bus_req,
    input  o_bus_addr,
    input  o_bus_we,
    input  o_bus_wdata,
    output i_bus_ack,
    output i_bus_rdata
  );

endinterface

// File: rtl/lsu_sequencer.sv
// Load/store sequencer between the CPU memory stage and a word-wide data bus.
// Runs one byte/halfword/word access at a time, splitting misaligned accesses
// into two aligned beats and formatting load data into a register-ready word.
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   i_req          : request, sampled only while idle
//   i_we           : 1 = store, 0 = load
//   i_addr         : byte address
//   i_wdata        : store data, LSB-aligned
//   i_length       : 0 byte, 1 halfword, 2 word, 3 illegal
//   i_signed       : sign-extend byte/halfword load results
//   o_busy         : high whenever not idle (pipeline stall)
//   o_done         : one-cycle completion pulse
//   o_err          : one-cycle pulse with o_done for an illegal length
//   o_rdata        : load result, held until the next load completes
//   bus            : data-bus master port
module lsu_sequencer #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [1:0]        i_length,
  input  logic              i_signed,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [31:0]       o_rdata,
  lsu_sequencer_if.master   bus
);

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1} state_e;

  state_e      state_q;
  logic        we_q;
  logic [1:0]  off_q;
  logic [1:0]  len_q;
  logic        sgn_q;
  logic [7:0]  mask_q;
  logic [31:0] lo_q;

  logic [3:0]  base_mask;
  logic [7:0]  req_mask;

  // Byte mask over two adjacent words; the upper nibble is the second beat.
  always_comb begin
    base_mask = 4'b1111;
    case (i_length)
      2'd0:    base_mask = 4'b0001;
      2'd1:    base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    req_mask = {4'b0000, base_mask} << i_addr[1:0];
  end

  assign o_busy = (state_q != StIdle);

  // Rotate store data into its byte lanes; both beats reuse the same word.
  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] off);
    logic [63:0] dd;
    dd = {d, d} << {off, 3'b000};
    return dd[63:32];
  endfunction

  function automatic logic [31:0] format_load(input logic [63:0] hi_lo, input logic [1:0] off,
                                              input logic [1:0] len, input logic sgn);
    logic [63:0] sh;
    logic [31:0] w;
    sh = hi_lo >> {off, 3'b000};
    w  = sh[31:0];
    case (len)
      2'd0:    return sgn ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
      2'd1:    return sgn ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= StIdle;
      we_q            <= 1'b0;
      off_q           <= 2'd0;
      len_q           <= 2'd0;
      sgn_q           <= 1'b0;
      mask_q          <= 8'h00;
      lo_q            <= 32'h0;
      o_done          <= 1'b0;
      o_err           <= 1'b0;
      o_rdata         <= 32'h0;
      bus.o_bus_req   <= 1'b0;
      bus.o_bus_addr  <= '0;
      bus.o_bus_we    <= 4'b0000;
      bus.o_bus_wdata <= 32'h0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_req) begin
            we_q   <= i_we;
            off_q  <= i_addr[1:0];
            len_q  <= i_length;
            sgn_q  <= i_signed;
            mask_q <= req_mask;
            if (i_length == 2'd3) begin
              // Illegal length: report immediately, never touch the bus.
              o_done <= 1'b1;
              o_err  <= 1'b1;
            end else begin
              state_q         <= StBeat0;
              bus.o_bus_req   <= 1'b1;
              bus.o_bus_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
              bus.o_bus_we    <= i_we ? req_mask[3:0] : 4'b0000;
              bus.o_bus_wdata <= rotl_bytes(i_wdata, i_addr[1:0]);
            end
          end
        end
        StBeat0: begin
          if (bus.i_bus_ack) begin
            lo_q <= bus.i_bus_rdata;
            if (mask_q[7:4] != 4'b0000) begin
              // Keep the request asserted so the second beat follows without a gap.
              state_q        <= StBeat1;
              bus.o_bus_addr <= bus.o_bus_addr + ADDR_W'(4);
              bus.o_bus_we   <= we_q ? mask_q[7:4] : 4'b0000;
            end else begin
              state_q       <= StIdle;
              bus.o_bus_req <= 1'b0;
              o_done        <= 1'b1;
              if (!we_q) o_rdata <= format_load({32'h0, bus.i_bus_rdata}, off_q, len_q, sgn_q);
            end
          end
        end
        StBeat1: begin
          if (bus.i_bus_ack) begin
            state_q       <= StIdle;
            bus.o_bus_req <= 1'b0;
            o_done        <= 1'b1;
            if (!we_q) o_rdata <= format_load({bus.i_bus_rdata, lo_q}, off_q, len_q, sgn_q);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed testbench for lsu_sequencer with a queue-based scoreboard: each step
// pushes its request, the bus beats it must produce and its completion result;
// the service loop plays the bus responder and pops/compares as the DUT acts.
module tb_lsu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  len;
  logic        sgn;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  lsu_sequencer_if #(.ADDR_W(32)) bus_if ();

  lsu_sequencer #(.ADDR_W(32)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (req),
    .i_we     (we),
    .i_addr   (addr),
    .i_wdata  (wdata),
    .i_length (len),
    .i_signed (sgn),
    .o_busy   (busy),
    .o_done   (done),
    .o_err    (err),
    .o_rdata  (rdata),
    .bus      (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  len;
    logic        sgn;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } res_t;

  req_t  req_q[$];
  beat_t beat_q[$];
  res_t  res_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] model_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] l, input logic s);
    req_t r;
    r.we = w; r.addr = a; r.wdata = d; r.len = l; r.sgn = s;
    req_q.push_back(r);
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                           input logic [31:0] rd, input int dly);
    beat_t b;
    b.addr = a; b.we = w; b.wdata = d; b.rdata = rd; b.delay = dly;
    beat_q.push_back(b);
  endtask

  // Loads update the bench's copy of o_rdata; stores and errors expect it unchanged.
  task automatic push_res(input logic is_load, input logic [31:0] v, input logic e, input int lat);
    res_t r;
    if (is_load) model_rdata = v;
    r.rdata = model_rdata; r.err = e; r.lat = lat;
    res_q.push_back(r);
  endtask

  // Called at a negedge: drive the next queued request (or drop i_req) and restart latency.
  task automatic load_next();
    req_t r;
    if (req_q.size() > 0) begin
      r = req_q.pop_front();
      req = 1'b1; we = r.we; addr = r.addr; wdata = r.wdata; len = r.len; sgn = r.sgn;
      cyc = 0;
    end else begin
      req = 1'b0;
    end
  endtask

  // Requests are held high until their done cycle, as a stalled pipeline would.
  task automatic run(input int n_done);
    int dones = 0;
    int wait_cnt = 0;
    int guard = 0;
    beat_t b;
    res_t r;
    load_next();
    while (dones < n_done) begin
      @(negedge clk);
      cyc++;
      guard++;
      bus_if.i_bus_ack = 1'b0;
      if (guard > 100) begin
        check("timeout", 32'(guard), 32'd100);
        req = 1'b0;
        break;
      end
      if (done) begin
        dones++;
        check("result_available", 32'(res_q.size() > 0), 32'd1);
        if (res_q.size() > 0) begin
          r = res_q.pop_front();
          check("rdata", rdata, r.rdata);
          check("err", 32'(err), 32'(r.err));
          if (r.lat > 0) check("latency", 32'(cyc), 32'(r.lat));
        end
        load_next();
      end
      if (bus_if.o_bus_req) begin
        check("busy_during_req", 32'(busy), 32'd1);
        check("beat_expected", 32'(beat_q.size() > 0), 32'd1);
        if (beat_q.size() > 0) begin
          if (wait_cnt == beat_q[0].delay) begin
            b = beat_q.pop_front();
            check("bus_addr", bus_if.o_bus_addr, b.addr);
            check("bus_we", 32'(bus_if.o_bus_we), 32'(b.we));
            check("bus_wdata", bus_if.o_bus_wdata, b.wdata);
            bus_if.i_bus_ack   = 1'b1;
            bus_if.i_bus_rdata = b.rdata;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
    check("beats_consumed", 32'(beat_q.size()), 32'd0);
    // Nothing further may happen once every queued access has completed.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus_if.i_bus_ack = 1'b0;
      check("quiet_done", 32'(done), 32'd0);
      check("quiet_bus_req", 32'(bus_if.o_bus_req), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; len = 2'd0; sgn = 1'b0;
    bus_if.i_bus_ack = 1'b0;
    bus_if.i_bus_rdata = 32'h0;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_bus_req", 32'(bus_if.o_bus_req), 32'd0);
    check("rst_bus_addr", bus_if.o_bus_addr, 32'h0);
    check("rst_bus_we", 32'(bus_if.o_bus_we), 32'd0);
    check("rst_bus_wdata", bus_if.o_bus_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Spurious ack while idle is ignored
    bus_if.i_bus_ack = 1'b1;
    bus_if.i_bus_rdata = 32'h5A5A5A5A;
    repeat (2) @(negedge clk);
    check("spurious_bus_req", 32'(bus_if.o_bus_req), 32'd0);
    check("spurious_done", 32'(done), 32'd0);
    check("spurious_busy", 32'(busy), 32'd0);
    check("spurious_rdata", rdata, 32'h0);
    bus_if.i_bus_ack = 1'b0;

    // Aligned word store, immediate ack
    push_req(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'd2, 1'b0);
    push_beat(32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0, 0);
    push_res(1'b0, 32'h0, 1'b0, 2);
    run(1);

    // Signed byte load at offset 3, three wait cycles
    push_req(1'b0, 32'h0000_0203, 32'h0, 2'd0, 1'b1);
    push_beat(32'h0000_0200, 4'b0000, 32'h0, 32'h8012_3456, 3);
    push_res(1'b1, 32'hFFFF_FF80, 1'b0, 5);
    run(1);

    // Misaligned halfword store split across a word boundary
    push_req(1'b1, 32'h0000_00FF, 32'h0000_ABCD, 2'd1, 1'b0);
    push_beat(32'h0000_00FC, 4'b1000, 32'hCD00_00AB, 32'h0, 0);
    push_beat(32'h0000_0100, 4'b0001, 32'hCD00_00AB, 32'h0, 0);
    push_res(1'b0, 32'h0, 1'b0, 3);
    run(1);

    // Misaligned unsigned word load wrapping the top of the address space
    push_req(1'b0, 32'hFFFF_FFFE, 32'h0, 2'd2, 1'b0);
    push_beat(32'hFFFF_FFFC, 4'b0000, 32'h0, 32'h3344_0000, 0);
    push_beat(32'h0000_0000, 4'b0000, 32'h0, 32'h0000_1122, 0);
    push_res(1'b1, 32'h1122_3344, 1'b0, 3);
    run(1);

    // Byte store at offset 2, one wait cycle
    push_req(1'b1, 32'h0000_0012, 32'h0000_00A5, 2'd0, 1'b0);
    push_beat(32'h0000_0010, 4'b0100, 32'h00A5_0000, 32'h0, 1);
    push_res(1'b0, 32'h0, 1'b0, 3);
    run(1);

    // Illegal length: done+err next cycle, no bus activity, rdata unchanged
    push_req(1'b0, 32'h0000_0040, 32'h0, 2'd3, 1'b0);
    push_res(1'b0, 32'h0, 1'b1, 1);
    run(1);

    // Held request, then a back-to-back request taken in the done cycle
    push_req(1'b0, 32'h0000_0402, 32'h0, 2'd1, 1'b0);
    push_beat(32'h0000_0400, 4'b0000, 32'h0, 32'hBEEF_1234, 2);
    push_res(1'b1, 32'h0000_BEEF, 1'b0, 4);
    push_req(1'b0, 32'h0000_0500, 32'h0, 2'd1, 1'b1);
    push_beat(32'h0000_0500, 4'b0000, 32'h0, 32'h0000_8001, 0);
    push_res(1'b1, 32'hFFFF_8001, 1'b0, 2);
    run(2);

    // Reset while the second beat of a misaligned load is waiting
    req = 1'b1; we = 1'b0; addr = 32'h0000_0301; wdata = 32'h0; len = 2'd2; sgn = 1'b0;
    @(negedge clk);
    check("rstmid_beat0_req", 32'(bus_if.o_bus_req), 32'd1);
    check("rstmid_beat0_addr", bus_if.o_bus_addr, 32'h0000_0300);
    bus_if.i_bus_ack = 1'b1;
    bus_if.i_bus_rdata = 32'h1111_1111;
    @(negedge clk);
    bus_if.i_bus_ack = 1'b0;
    check("rstmid_beat1_req", 32'(bus_if.o_bus_req), 32'd1);
    check("rstmid_beat1_addr", bus_if.o_bus_addr, 32'h0000_0304);
    req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_bus_req", 32'(bus_if.o_bus_req), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_rdata = 32'h0;
    check("rstmid_rdata", rdata, 32'h0);

    // Aligned load after reset completes normally
    push_req(1'b0, 32'h0000_0600, 32'h0, 2'd2, 1'b0);
    push_beat(32'h0000_0600, 4'b0000, 32'h0, 32'hCAFE_F00D, 0);
    push_res(1'b1, 32'hCAFE_F00D, 1'b0, 2);
    run(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
